// File: rtl/spi_tx_scheduler.sv
// Shares the SPI slave serialiser send channel among NREQ requesters and forwards inbound commands.
// Define SCHED_FIXED_PRIO_EN to use fixed lowest-index-wins priority instead of round-robin.
module spi_tx_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DATA_W  = 48,
    parameter int unsigned TMO_CYC = 65535,
    parameter int unsigned ACK_WIN = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ*3-1:0]      req_type,
    input  logic [NREQ*4-1:0]      req_len,
    output logic [NREQ-1:0]        grant,
    output logic                   spi_send_trigger,
    output logic [DATA_W-1:0]      spi_output_data,
    output logic [2:0]             spi_msg_type,
    output logic [3:0]             spi_byte_count,
    output logic                   spi_long_coming,
    output logic                   spi_rst,
    input  logic                   spi_busy,
    input  logic                   spi_received,
    input  logic [15:0]            spi_rx_data,
    input  logic                   long_expect,
    output logic                   cmd_valid,
    output logic [15:0]            cmd_data,
    output logic                   tmo_err,
    input  logic                   err_clr
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef SCHED_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitAck,
        StWaitDone,
        StRecover
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   win_q, win_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        type_q, type_d;
    logic [3:0]        count_q, count_d;
    logic              long_q, long_d;
    logic              rst_pulse_q, rst_pulse_d;
    logic              tmo_q, tmo_d;
    logic              cmd_valid_q;
    logic [15:0]       cmd_data_q;

    logic [IdxW-1:0]   pick;
    logic              found;
    int unsigned       rr_idx;
    logic [2:0]        sel_type;
    logic [3:0]        sel_len;
    logic [3:0]        sel_count;

    // Search upward from the pointer with wrap; fixed priority always starts at 0.
    always_comb begin
        pick   = '0;
        found  = 1'b0;
        rr_idx = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rr_idx = i;
            if (!FixedPrio) begin
                rr_idx = rr_idx + 32'(ptr_q);
                if (rr_idx >= NREQ) begin
                    rr_idx = rr_idx - NREQ;
                end
            end
            if (!found && req[rr_idx[IdxW-1:0]]) begin
                found = 1'b1;
                pick  = rr_idx[IdxW-1:0];
            end
        end
    end

    always_comb begin
        sel_type = req_type[pick*3 +: 3];
        sel_len  = req_len[pick*4 +: 4];
        case (sel_type)
            3'b001:  sel_count = 4'd1;
            3'b011:  sel_count = 4'd3;
            3'b110:  sel_count = 4'd6;
            3'b111:  sel_count = sel_len;
            default: sel_count = 4'd2;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        type_d      = type_q;
        count_d     = count_q;
        long_d      = long_q;
        rst_pulse_d = 1'b0;
        tmo_d       = tmo_q & ~err_clr;
        grant       = '0;

        unique case (state_q)
            StIdle: begin
                // A busy serialiser here means an inbound receive is in progress.
                if (!spi_busy) begin
                    long_d = long_expect;
                    if (found) begin
                        win_d   = pick;
                        data_d  = req_data[pick*DATA_W +: DATA_W];
                        type_d  = sel_type;
                        count_d = sel_count;
                        state_d = StLaunch;
                    end
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (spi_busy) begin
                    cnt_d   = '0;
                    state_d = StWaitDone;
                end else if (cnt_q == 16'(ACK_WIN - 1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWaitDone: begin
                if (!spi_busy) begin
                    grant[win_q] = 1'b1;
                    if (FixedPrio || (win_q == IdxW'(NREQ - 1))) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_q + 1'b1;
                    end
                    state_d = StIdle;
                end else if (cnt_q == 16'(TMO_CYC - 1)) begin
                    // Timeout overrides a simultaneous err_clr.
                    rst_pulse_d = 1'b1;
                    tmo_d       = 1'b1;
                    state_d     = StRecover;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRecover: begin
                if (!spi_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            type_q      <= '0;
            count_q     <= '0;
            long_q      <= 1'b0;
            rst_pulse_q <= 1'b0;
            tmo_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            type_q      <= type_d;
            count_q     <= count_d;
            long_q      <= long_d;
            rst_pulse_q <= rst_pulse_d;
            tmo_q       <= tmo_d;
            // received only marks a completed receive, so it is forwarded in every state.
            cmd_valid_q <= spi_received;
            if (spi_received) begin
                cmd_data_q <= spi_rx_data;
            end
        end
    end

    assign spi_send_trigger = (state_q == StLaunch);
    assign spi_output_data  = data_q;
    assign spi_msg_type     = type_q;
    assign spi_byte_count   = count_q;
    assign spi_long_coming  = long_q;
    assign spi_rst          = rst_pulse_q;
    assign tmo_err          = tmo_q;
    assign cmd_valid        = cmd_valid_q;
    assign cmd_data         = cmd_data_q;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed bench for spi_tx_scheduler with a behavioural serialiser and grant/command scoreboards.
module tb_spi_tx_scheduler;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned DATA_W  = 48;
    localparam int unsigned TMO_CYC = 100;
    localparam int unsigned ACK_WIN = 3;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ*3-1:0]      req_type;
    logic [NREQ*4-1:0]      req_len;
    logic [NREQ-1:0]        grant;
    logic                   spi_send_trigger;
    logic [DATA_W-1:0]      spi_output_data;
    logic [2:0]             spi_msg_type;
    logic [3:0]             spi_byte_count;
    logic                   spi_long_coming;
    logic                   spi_rst;
    logic                   spi_busy;
    logic                   spi_received;
    logic [15:0]            spi_rx_data;
    logic                   long_expect;
    logic                   cmd_valid;
    logic [15:0]            cmd_data;
    logic                   tmo_err;
    logic                   err_clr;

    spi_tx_scheduler #(
        .NREQ   (NREQ),
        .DATA_W (DATA_W),
        .TMO_CYC(TMO_CYC),
        .ACK_WIN(ACK_WIN)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .req             (req),
        .req_data        (req_data),
        .req_type        (req_type),
        .req_len         (req_len),
        .grant           (grant),
        .spi_send_trigger(spi_send_trigger),
        .spi_output_data (spi_output_data),
        .spi_msg_type    (spi_msg_type),
        .spi_byte_count  (spi_byte_count),
        .spi_long_coming (spi_long_coming),
        .spi_rst         (spi_rst),
        .spi_busy        (spi_busy),
        .spi_received    (spi_received),
        .spi_rx_data     (spi_rx_data),
        .long_expect     (long_expect),
        .cmd_valid       (cmd_valid),
        .cmd_data        (cmd_data),
        .tmo_err         (tmo_err),
        .err_clr         (err_clr)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  g;
        logic [47:0] d;
        logic [3:0]  n;
    } gexp_t;

    gexp_t       exp_q[$];
    logic [15:0] exp_cmd[$];
    gexp_t       mon_e;
    logic [15:0] mon_c;

    // Per-requester payloads and the byte counts their types imply.
    logic [47:0] rq_data[NREQ] = '{48'h0000_0000_A55A, 48'h1111_2222_3333,
                                   48'h4444_5555_6666, 48'h7777_8888_99AA};
    logic [2:0]  rq_type[NREQ] = '{3'b010, 3'b111, 3'b110, 3'b001};
    logic [3:0]  rq_len[NREQ]  = '{4'd9, 4'd5, 4'd12, 4'd7};
    logic [3:0]  rq_cnt[NREQ]  = '{4'd2, 4'd5, 4'd6, 4'd1};

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int grant_seen = 0;
    int trig_cnt = 0;
    int rst_cnt = 0;
    int last_trig_cyc = 0;
    int prev_trig_cyc = 0;
    int busy_left = 0;
    int ser_mode = 0;  // 0 normal, 1 never acks, 2 busy stuck until spi_rst
    logic ser_busy = 1'b0;
    logic rx_busy = 1'b0;

    assign spi_busy = ser_busy | rx_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_grant(input int i);
        gexp_t e;
        e.g = 4'(1 << i);
        e.d = rq_data[i];
        e.n = rq_cnt[i];
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input int target, input int budget, input string tag);
        int n = 0;
        while (grant_seen < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(grant_seen), 64'(target));
    endtask

    task automatic wait_trig(input int target, input int budget, input string tag);
        int n = 0;
        while (trig_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(trig_cnt), 64'(target));
    endtask

    task automatic wait_spi_rst(input int budget, input string tag);
        int n = 0;
        while (spi_rst !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(spi_rst), 64'd1);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Serialiser model, sampled just after each clock edge.
    initial begin
        forever begin
            tick();
            if (RST) begin
                ser_busy = 1'b0;
            end else if (spi_rst) begin
                rst_cnt++;
                ser_busy = 1'b0;
            end else if (spi_send_trigger) begin
                trig_cnt++;
                prev_trig_cyc = last_trig_cyc;
                last_trig_cyc = cyc;
                if (ser_mode == 0) begin
                    ser_busy  = 1'b1;
                    busy_left = 20;
                end else if (ser_mode == 2) begin
                    ser_busy = 1'b1;
                end
            end else if (ser_busy && ser_mode == 0) begin
                busy_left--;
                if (busy_left == 0) ser_busy = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (grant != '0) begin
            grant_seen++;
            if (exp_q.size() == 0) begin
                chk("grant_unexpected", 64'(grant), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("grant", 64'(grant), 64'(mon_e.g));
                chk("out_data", 64'(spi_output_data), 64'(mon_e.d));
                chk("byte_count", 64'(spi_byte_count), 64'(mon_e.n));
            end
        end
        if (cmd_valid === 1'b1) begin
            if (exp_cmd.size() == 0) begin
                chk("cmd_unexpected", 64'(cmd_valid), 64'd0);
            end else begin
                mon_c = exp_cmd.pop_front();
                chk("cmd_data", 64'(cmd_data), 64'(mon_c));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int t0;
        int g0;
        RST          = 1'b1;
        req          = '0;
        spi_received = 1'b0;
        spi_rx_data  = '0;
        long_expect  = 1'b0;
        err_clr      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = rq_data[i];
            req_type[i*3 +: 3]           = rq_type[i];
            req_len[i*4 +: 4]            = rq_len[i];
        end
        repeat (3) tick();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_trigger", 64'(spi_send_trigger), 64'd0);
        chk("rst_data", 64'(spi_output_data), 64'd0);
        chk("rst_type", 64'(spi_msg_type), 64'd0);
        chk("rst_count", 64'(spi_byte_count), 64'd0);
        chk("rst_spi_rst", 64'(spi_rst), 64'd0);
        chk("rst_tmo_err", 64'(tmo_err), 64'd0);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        RST = 1'b0;
        tick();

        // Round-robin from pointer 0 with all requesters held.
        t0 = trig_cnt;
        g0 = grant_seen;
        push_grant(0); push_grant(1); push_grant(2); push_grant(3); push_grant(0);
        req = 4'b1111;
        wait_grant(g0 + 5, 300, "rr_five_grants");
        req = '0;
        chk("rr_trigger_count", 64'(trig_cnt - t0), 64'd5);

        // Single requester wraps from pointer 1; long_coming frozen while sending.
        long_expect = 1'b1;
        tick(); tick();
        chk("long_idle_update", 64'(spi_long_coming), 64'd1);
        t0 = trig_cnt;
        g0 = grant_seen;
        push_grant(0);
        req = 4'b0001;
        wait_trig(t0 + 1, 20, "t1_trigger");
        repeat (3) tick();
        exp_cmd.push_back(16'hBEEF);
        spi_rx_data  = 16'hBEEF;
        spi_received = 1'b1;
        tick();
        spi_received = 1'b0;
        long_expect  = 1'b0;
        tick(); tick();
        chk("long_frozen", 64'(spi_long_coming), 64'd1);
        wait_grant(g0 + 1, 60, "t1_grant");
        req = '0;
        chk("t1_one_trigger", 64'(trig_cnt - t0), 64'd1);
        tick(); tick();
        chk("long_idle_release", 64'(spi_long_coming), 64'd0);

        // Inbound receive holds off arbitration; command forwarded one cycle later.
        rx_busy = 1'b1;
        t0 = trig_cnt;
        g0 = grant_seen;
        req = 4'b0010;
        repeat (3) tick();
        exp_cmd.push_back(16'h1234);
        spi_rx_data  = 16'h1234;
        spi_received = 1'b1;
        tick();
        spi_received = 1'b0;
        chk("cmd_valid_next", 64'(cmd_valid), 64'd1);
        chk("cmd_data_next", 64'(cmd_data), 64'h1234);
        spi_rx_data = 16'h0000;
        tick();
        chk("cmd_valid_pulse", 64'(cmd_valid), 64'd0);
        chk("cmd_data_hold", 64'(cmd_data), 64'h1234);
        repeat (5) tick();
        chk("busy_blocks_arb", 64'(trig_cnt - t0), 64'd0);
        push_grant(1);
        rx_busy = 1'b0;
        wait_grant(g0 + 1, 60, "t3_grant");
        req = '0;

        // Serialiser never acks: re-trigger after the ack window, no grant.
        ser_mode = 1;
        t0 = trig_cnt;
        g0 = grant_seen;
        req = 4'b0100;
        wait_trig(t0 + 2, 40, "noack_retrigger");
        chk("noack_gap", 64'(last_trig_cyc - prev_trig_cyc), 64'(ACK_WIN + 2));
        chk("noack_no_grant", 64'(grant_seen), 64'(g0));
        ser_mode = 0;
        push_grant(2);
        wait_grant(g0 + 1, 80, "noack_recovered_grant");
        req = '0;

        // Stuck busy: timeout, sticky error, err_clr, timeout beats err_clr, retry.
        ser_mode = 2;
        t0 = rst_cnt;
        g0 = grant_seen;
        req = 4'b1000;
        wait_spi_rst(200, "tmo1_spi_rst");
        chk("tmo1_cycle", 64'(cyc - last_trig_cyc), 64'(TMO_CYC + 2));
        chk("tmo1_err", 64'(tmo_err), 64'd1);
        tick();
        chk("tmo1_rst_pulse", 64'(spi_rst), 64'd0);
        tick();
        chk("tmo1_err_sticky", 64'(tmo_err), 64'd1);
        err_clr = 1'b1;
        tick();
        chk("err_clr_clears", 64'(tmo_err), 64'd0);
        wait_spi_rst(200, "tmo2_spi_rst");
        chk("tmo2_cycle", 64'(cyc - last_trig_cyc), 64'(TMO_CYC + 2));
        chk("tmo_beats_clr", 64'(tmo_err), 64'd1);
        err_clr  = 1'b0;
        ser_mode = 0;
        push_grant(3);
        wait_grant(g0 + 1, 80, "tmo_retry_grant");
        req = '0;
        chk("tmo_rst_pulses", 64'(rst_cnt - t0), 64'd2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo_final_clear", 64'(tmo_err), 64'd0);

        // Asynchronous reset mid-send also clears the pointer.
        g0 = grant_seen;
        push_grant(0);
        req = 4'b0001;
        wait_grant(g0 + 1, 60, "t6_pre_grant");
        req = 4'b0100;
        begin
            int n = 0;
            while (!ser_busy && n < 30) begin
                tick();
                n++;
            end
        end
        chk("t6_in_flight", 64'(ser_busy), 64'd1);
        repeat (5) tick();
        #3;
        RST = 1'b1;
        #1;
        chk("arst_grant", 64'(grant), 64'd0);
        chk("arst_trigger", 64'(spi_send_trigger), 64'd0);
        chk("arst_data", 64'(spi_output_data), 64'd0);
        chk("arst_count", 64'(spi_byte_count), 64'd0);
        chk("arst_type", 64'(spi_msg_type), 64'd0);
        req = '0;
        tick(); tick();
        RST = 1'b0;
        g0 = grant_seen;
        push_grant(0);
        req = 4'b0011;
        wait_grant(g0 + 1, 60, "arst_ptr_zero_grant");
        req = '0;
        repeat (3) tick();

        chk("grant_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
